bit_serializer_p2s: RTL and testbench

//  Parallel-to-serial front end for the serial sequence detectors (e.g. 1001 Moore detector).

---
 rtl/ser_pkg.sv | 25 ++
 rtl/ser_hold_buf.sv | 51 +++++
 rtl/bit_serializer_p2s.sv | 176 +++++++++++++++++
 tb/tb_bit_serializer_p2s.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
// Optional build macro: SER_PARITY_EN adds the PARITY state (one even-parity bit per frame).
package ser_pkg;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } ser_state_t;
`endif

    localparam logic SER_IDLE_BIT_DEFAULT = 1'b0;

    // Bit counter only has to reach W-1; keep at least one bit for tiny widths.
    function automatic int ser_cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register between the upstream valid/ready handshake and the shifter.
// A word can be accepted on the same edge the held word is transferred out.
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         xfer,
    output logic         hold_full,
    output logic [W-1:0] hold_data
);

    logic         hold_full_q;
    logic         hold_full_d;
    logic [W-1:0] hold_data_q;
    logic [W-1:0] hold_data_d;
    logic         accept;

    // An accept on the transfer edge reloads the entry, so it stays full.
    always_comb begin
        in_ready    = !rst && (!hold_full_q || xfer);
        accept      = in_valid && in_ready;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
        end else if (xfer) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign hold_full = hold_full_q;
    assign hold_data = hold_data_q;

endmodule

// File: rtl/bit_serializer_p2s.sv
// Parallel-to-serial front end: W-bit words in on valid/ready, one registered bit per clk out.
// Build macro SER_PARITY_EN appends an even-parity bit to every frame.
module bit_serializer_p2s
    import ser_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = SER_IDLE_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_bit,
    output logic         ser_valid,
    output logic         word_done,
    output logic         busy
);

    localparam int               CNT_W    = ser_cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic         hold_full;
    logic [W-1:0] hold_data;
    logic         xfer;

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_next;
    logic [W-1:0]     shift_q;
    logic [W-1:0]     shift_d;
    logic [W-1:0]     shift_adv;
    logic             ser_bit_q;
    logic             ser_bit_d;
    logic             ser_valid_q;
    logic             ser_valid_d;
    logic             word_done_q;
    logic             word_done_d;
`ifdef SER_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    ser_hold_buf #(
        .W(W)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xfer     (xfer),
        .hold_full(hold_full),
        .hold_data(hold_data)
    );

    // The shifter always presents the next bit at the same end of the register.
    function automatic logic out_bit(input logic [W-1:0] v);
        return MSB_FIRST ? v[W-1] : v[0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // state_q names what the output registers are showing this cycle.
    always_comb begin
        state_d = state_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    xfer    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    if (hold_full) begin
                        xfer = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (hold_full) begin
                    xfer    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_adv   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        cnt_next    = cnt_q + CNT_ONE;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ser_bit_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif
        if (xfer) begin
            shift_d     = hold_data;
            cnt_d       = '0;
            ser_bit_d   = out_bit(hold_data);
            ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            parity_d    = ^hold_data;
`endif
        end else if (state_q == SHIFT && cnt_q != CNT_LAST) begin
            shift_d     = shift_adv;
            cnt_d       = cnt_next;
            ser_bit_d   = out_bit(shift_adv);
            ser_valid_d = 1'b1;
`ifndef SER_PARITY_EN
            word_done_d = (cnt_next == CNT_LAST);
`endif
        end
`ifdef SER_PARITY_EN
        else if (state_q == SHIFT) begin
            ser_bit_d   = parity_q;
            ser_valid_d = 1'b1;
            word_done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            ser_bit_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != IDLE) || hold_full;

endmodule

// File: tb/tb_bit_serializer_p2s.sv
// Bench for bit_serializer_p2s: an MSB-first/idle-0 and an LSB-first/idle-1 instance share inputs;
// expected frames come from a cycle-scheduled model of accepted words (honours SER_PARITY_EN).
module tb_bit_serializer_p2s;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct {
        int           acc;
        int           start;
        logic [W-1:0] word;
    } frame_t;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;

    logic in_ready_m, ser_bit_m, ser_valid_m, word_done_m, busy_m;
    logic in_ready_l, ser_bit_l, ser_valid_l, word_done_l, busy_l;

    int     tests    = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     last_end = -100;
    frame_t frames[$];
    bit     acc;

    always #5 clk = ~clk;

    bit_serializer_p2s #(
        .W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
    ) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_m),
        .ser_bit  (ser_bit_m),
        .ser_valid(ser_valid_m),
        .word_done(word_done_m),
        .busy     (busy_m)
    );

    bit_serializer_p2s #(
        .W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
    ) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_l),
        .ser_bit  (ser_bit_l),
        .ser_valid(ser_valid_l),
        .word_done(word_done_l),
        .busy     (busy_l)
    );

    // Bit k of a frame: data bits in the chosen order, then the even-parity bit.
    function automatic logic frame_bit(input logic [W-1:0] word, input int k, input bit msb);
        if (k >= W) return ^word;
        return msb ? word[W-1-k] : word[k];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic         exp_valid;
        logic         exp_done;
        logic         hold_exp;
        int           k;
        logic [W-1:0] word;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        hold_exp  = 1'b0;
        k         = 0;
        word      = '0;
        while (frames.size() > 0 && cyc >= frames[0].start + FRAME) frames.delete(0);
        if (frames.size() > 0 && cyc >= frames[0].start) begin
            exp_valid = 1'b1;
            k         = cyc - frames[0].start;
            word      = frames[0].word;
            exp_done  = (k == FRAME - 1);
        end
        foreach (frames[i]) if (frames[i].acc < cyc && frames[i].start > cyc) hold_exp = 1'b1;
        check_bit("msb_ser_valid", ser_valid_m, exp_valid);
        check_bit("lsb_ser_valid", ser_valid_l, exp_valid);
        check_bit("msb_ser_bit", ser_bit_m, exp_valid ? frame_bit(word, k, 1'b1) : 1'b0);
        check_bit("lsb_ser_bit", ser_bit_l, exp_valid ? frame_bit(word, k, 1'b0) : 1'b1);
        check_bit("msb_word_done", word_done_m, exp_done);
        check_bit("lsb_word_done", word_done_l, exp_done);
        check_bit("msb_busy", busy_m, exp_valid || hold_exp);
        check_bit("lsb_busy", busy_l, exp_valid || hold_exp);
    endtask

    // A word accepted in cycle a starts at a+2, or right after the previous frame ends.
    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d,
                                 output bit accepted);
        int     st;
        logic   ready_exp;
        frame_t f;
        @(negedge clk);
        cyc++;
        checkOutput();
        rst      = r;
        in_valid = v;
        in_data  = d;
        if (r) begin
            frames.delete();
            last_end = -100;
        end
        #1;
        ready_exp = !r;
        foreach (frames[i]) if (frames[i].acc < cyc && frames[i].start > cyc + 1) ready_exp = 1'b0;
        check_bit("msb_in_ready", in_ready_m, ready_exp);
        check_bit("lsb_in_ready", in_ready_l, ready_exp);
        accepted = v && ready_exp;
        if (accepted) begin
            st      = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            f.acc   = cyc;
            f.start = st;
            f.word  = d;
            frames.push_back(f);
            last_end = st + FRAME - 1;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, W'($urandom), a);
    endtask

    initial begin
        repeat (3) applyStimulus(1'b1, 1'b0, '0, acc);

        applyStimulus(1'b0, 1'b1, 8'h99, acc);
        idle(FRAME + 3);

        // Back-to-back words, then a third word held against a full hold register.
        applyStimulus(1'b0, 1'b1, 8'hA5, acc);
        applyStimulus(1'b0, 1'b1, 8'h3C, acc);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) applyStimulus(1'b0, 1'b1, 8'hFF, acc);
        tests++;
        assert (acc) else begin
            failures++;
            $error("FAIL ff_accept: observed not accepted expected accepted within 40 cycles");
        end
        idle(3 * FRAME);

        // Reset after three bits of 8'hF0, with a word offered during reset.
        applyStimulus(1'b0, 1'b1, 8'hF0, acc);
        idle(3);
        applyStimulus(1'b1, 1'b1, 8'h55, acc);
        applyStimulus(1'b0, 1'b0, '0, acc);
        idle(4);

        applyStimulus(1'b0, 1'b1, 8'h07, acc);
        applyStimulus(1'b0, 1'b1, 8'h03, acc);
        applyStimulus(1'b0, 1'b1, 8'h01, acc);
        idle(4 * FRAME);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          W'($urandom), acc);
        end
        idle(3 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
